// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the Gamepad Pmod transmit side: FSM state encoding,
// button bit positions within a 12-bit controller word, and default timing.
package gamepad_pmod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_LATCH,
    ST_GAP
  } state_e;

  // Bit positions in the 12-bit word {b,y,select,start,up,down,left,right,a,x,l,r}.
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  localparam int DEFAULT_BIT_WIDTH  = 12;
  localparam int DEFAULT_CLK_DIV    = 8;
  localparam int DEFAULT_GAP_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gamepad_pmod_serializer_if.sv
// Parallel-side request signals and 3-wire serial outputs of the serializer.
// The master drives the button word and enable; the slave is the serializer.
interface gamepad_pmod_serializer_if #(
  parameter int BIT_WIDTH = 12
);
  logic                 enable;
  logic [BIT_WIDTH-1:0] buttons;
  logic                 pmod_data;
  logic                 pmod_clk;
  logic                 pmod_latch;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output enable, buttons,
    input  pmod_data, pmod_clk, pmod_latch, busy, frame_done
  );

  modport slave (
    input  enable, buttons,
    output pmod_data, pmod_clk, pmod_latch, busy, frame_done
  );
endinterface

// File: rtl/gamepad_pmod_serializer.sv
// Gamepad Pmod transmitter: snapshots a button word, shifts it out MSB first
// on pmod_data/pmod_clk, then strobes pmod_latch and idles for a gap.
// All serial outputs are registered, computed from the next-state values.
module gamepad_pmod_serializer
  import gamepad_pmod_pkg::*;
#(
  parameter int BIT_WIDTH  = DEFAULT_BIT_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input logic                      clk,
  input logic                      reset,
  gamepad_pmod_serializer_if.slave pad
);

  localparam int DIV_MAX = max_int(CLK_DIV, GAP_CYCLES);
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int BIT_W   = $clog2(BIT_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_WIDTH - 1);

  state_e               state_q,      state_d;
  logic [DIV_W-1:0]     div_cnt_q,    div_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
  logic [BIT_WIDTH-1:0] shreg_q,      shreg_d;
  logic                 busy_q,       busy_d;
  logic                 data_q,       data_d;
  logic                 sclk_q,       sclk_d;
  logic                 latch_q,      latch_d;
  logic                 frame_done_q, frame_done_d;

  // Next-state, counters and next-cycle output values.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise a latch is inferred.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    busy_d    = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pad.enable) begin
          shreg_d   = pad.buttons;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_CLK_LO;
        end
      end

      ST_CLK_LO: begin
        if (div_cnt_q >= DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = ST_CLK_HI;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_CLK_HI: begin
        if (div_cnt_q >= DIV_LAST) begin
          div_cnt_d = '0;
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          state_d   = (bit_cnt_q == BIT_LAST) ? ST_LATCH : ST_CLK_LO;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_LATCH: begin
        if (div_cnt_q >= DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        if (div_cnt_q >= GAP_LAST) begin
          div_cnt_d = '0;
          if (pad.enable) begin
            shreg_d   = pad.buttons;
            bit_cnt_d = '0;
            state_d   = ST_CLK_LO;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Outputs follow the state being entered so the pins are registered.
    data_d       = ((state_d == ST_CLK_LO) || (state_d == ST_CLK_HI)) ?
                   shreg_d[BIT_WIDTH-1] : 1'b0;
    sclk_d       = (state_d == ST_CLK_HI);
    latch_d      = (state_d == ST_LATCH);
    frame_done_d = (state_d == ST_LATCH) && (div_cnt_d == DIV_LAST);
  end

  // State, counter, shift register and output registers; reset drops any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      busy_q       <= 1'b0;
      data_q       <= 1'b0;
      sclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      busy_q       <= busy_d;
      data_q       <= data_d;
      sclk_q       <= sclk_d;
      latch_q      <= latch_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pad.pmod_data  = data_q;
  assign pad.pmod_clk   = sclk_q;
  assign pad.pmod_latch = latch_q;
  assign pad.busy       = busy_q;
  assign pad.frame_done = frame_done_q;

endmodule

// File: tb/tb_gamepad_pmod_serializer.sv
// Directed bench: a 12-bit and a 24-bit serializer each feed a simple
// receiver model that shifts on pmod_clk rises and captures on latch rise.
module tb_gamepad_pmod_serializer;
  import gamepad_pmod_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  gamepad_pmod_serializer_if #(.BIT_WIDTH(12)) pad_a ();
  gamepad_pmod_serializer_if #(.BIT_WIDTH(24)) pad_b ();

  gamepad_pmod_serializer #(.BIT_WIDTH(12), .CLK_DIV(4), .GAP_CYCLES(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .pad   (pad_a)
  );

  gamepad_pmod_serializer #(.BIT_WIDTH(24), .CLK_DIV(4), .GAP_CYCLES(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .pad   (pad_b)
  );

  // Receiver model A: edge detection on sampled serial lines.
  logic        a_clk_prev = 1'b0, a_latch_prev = 1'b0;
  logic [11:0] a_sh = '0, a_word = '0;
  int          a_rises = 0, a_rises_at_latch = 0, a_latch_cnt = 0, a_fd_cnt = 0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    a_clk_prev   <= pad_a.pmod_clk;
    a_latch_prev <= pad_a.pmod_latch;
    if (reset) begin
      a_rises <= 0;
    end else begin
      if (pad_a.pmod_clk && !a_clk_prev) begin
        a_sh    <= {a_sh[10:0], pad_a.pmod_data};
        a_rises <= a_rises + 1;
      end
      if (pad_a.pmod_latch && !a_latch_prev) begin
        a_word           <= a_sh;
        a_rises_at_latch <= a_rises;
        a_rises          <= 0;
        a_latch_cnt      <= a_latch_cnt + 1;
      end
      if (pad_a.frame_done) a_fd_cnt <= a_fd_cnt + 1;
    end
  end

  // Receiver model B (24-bit, dual controller).
  logic        b_clk_prev = 1'b0, b_latch_prev = 1'b0;
  logic [23:0] b_sh = '0, b_word = '0;
  int          b_rises = 0, b_rises_at_latch = 0;

  always @(posedge clk) begin
    b_clk_prev   <= pad_b.pmod_clk;
    b_latch_prev <= pad_b.pmod_latch;
    if (reset) begin
      b_rises <= 0;
    end else begin
      if (pad_b.pmod_clk && !b_clk_prev) begin
        b_sh    <= {b_sh[22:0], pad_b.pmod_data};
        b_rises <= b_rises + 1;
      end
      if (pad_b.pmod_latch && !b_latch_prev) begin
        b_word           <= b_sh;
        b_rises_at_latch <= b_rises;
        b_rises          <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd_a(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pad_a.frame_done && n < budget);
    check({tag, "_timeout"}, 32'(!pad_a.frame_done), 32'd0);
  endtask

  task automatic wait_rises_a(input string tag, input int target, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_rises < target && n < budget);
    check({tag, "_timeout"}, 32'(a_rises < target), 32'd0);
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pad_a.busy && n < budget);
    check({tag, "_timeout"}, 32'(pad_a.busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  32'(pad_a.pmod_data),  32'd0);
    check({tag, "_clk"},   32'(pad_a.pmod_clk),   32'd0);
    check({tag, "_latch"}, 32'(pad_a.pmod_latch), 32'd0);
    check({tag, "_busy"},  32'(pad_a.busy),       32'd0);
    check({tag, "_done"},  32'(pad_a.frame_done), 32'd0);
  endtask

  initial begin
    int t0, t1, t2, lc, fdc;

    reset         = 1'b1;
    pad_a.enable  = 1'b0;
    pad_a.buttons = '0;
    pad_b.enable  = 1'b0;
    pad_b.buttons = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single frame A5C; first CLK_LO visible one edge after enable.
    pad_a.buttons = 12'hA5C;
    pad_a.enable  = 1'b1;
    @(negedge clk);
    check("load_data", 32'(pad_a.pmod_data), 32'd1);
    check("load_clk",  32'(pad_a.pmod_clk),  32'd0);
    check("load_busy", 32'(pad_a.busy),      32'd1);
    pad_a.enable = 1'b0;
    wait_fd_a("f1", 200);
    check("f1_latch_at_done", 32'(pad_a.pmod_latch), 32'd1);
    check("f1_word",   32'(a_word), 32'hA5C);
    check("f1_rises",  32'(a_rises_at_latch), 32'd12);
    check("f1_b",      32'(a_word[BTN_B]), 32'd1);
    check("f1_y",      32'(a_word[BTN_Y]), 32'd0);
    check("f1_select", 32'(a_word[BTN_SELECT]), 32'd1);
    check("f1_start",  32'(a_word[BTN_START]), 32'd0);
    repeat (8) @(negedge clk);
    check("gap_busy_last", 32'(pad_a.busy), 32'd1);
    check("gap_latch_low", 32'(pad_a.pmod_latch), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(pad_a.busy), 32'd0);
    check("f1_latch_count", 32'(a_latch_cnt), 32'd1);

    // Back-to-back frames: period 2*4*12 + 4 + 8 = 108.
    pad_a.buttons = 12'h3C3;
    pad_a.enable  = 1'b1;
    wait_fd_a("p0", 200);
    t0 = cyc;
    wait_fd_a("p1", 200);
    t1 = cyc;
    wait_fd_a("p2", 200);
    t2 = cyc;
    check("period_1", 32'(t1 - t0), 32'd108);
    check("period_2", 32'(t2 - t1), 32'd108);
    check("period_rises", 32'(a_rises_at_latch), 32'd12);
    check("period_word",  32'(a_word), 32'h3C3);
    pad_a.enable = 1'b0;
    wait_idle_a("period_idle", 200);

    // Buttons change mid-frame: snapshot only.
    pad_a.buttons = 12'h001;
    pad_a.enable  = 1'b1;
    wait_rises_a("chg_bit3", 4, 200);
    pad_a.buttons = 12'h800;
    wait_fd_a("chg_f1", 200);
    check("chg_first_word", 32'(a_word), 32'h001);
    wait_rises_a("chg_f2_start", 1, 200);
    pad_a.enable = 1'b0;
    wait_fd_a("chg_f2", 200);
    check("chg_second_word", 32'(a_word), 32'h800);
    wait_idle_a("chg_idle", 200);

    // Reset during bit 6: outputs clear at once, nothing delivered.
    pad_a.buttons = 12'h0F0;
    pad_a.enable  = 1'b1;
    wait_rises_a("rst_bit6", 6, 200);
    pad_a.enable = 1'b0;
    lc  = a_latch_cnt;
    fdc = a_fd_cnt;
    #2 reset = 1'b1;
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_word",   32'(a_word), 32'h800);
    check("midrst_latch",  32'(a_latch_cnt), 32'(lc));
    check("midrst_fd",     32'(a_fd_cnt), 32'(fdc));
    check("midrst_busy",   32'(pad_a.busy), 32'd0);

    // Drop enable during CLK_HI of bit 2: frame finishes, then stays idle.
    pad_a.buttons = 12'h5A5;
    pad_a.enable  = 1'b1;
    wait_rises_a("drop_bit2", 3, 200);
    check("drop_in_clk_hi", 32'(pad_a.pmod_clk), 32'd1);
    pad_a.enable = 1'b0;
    lc = a_latch_cnt;
    wait_fd_a("drop_fd", 200);
    wait_idle_a("drop_idle", 200);
    check("drop_word", 32'(a_word), 32'h5A5);
    repeat (30) @(negedge clk);
    check("drop_one_latch", 32'(a_latch_cnt), 32'(lc + 1));
    check("drop_busy_low",  32'(pad_a.busy), 32'd0);
    check("drop_no_clk",    32'(a_rises), 32'd0);

    // Dual controller 24-bit frame.
    pad_b.buttons = 24'hFFF123;
    pad_b.enable  = 1'b1;
    @(negedge clk);
    pad_b.enable = 1'b0;
    begin
      int n = 0;
      while (!pad_b.frame_done && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("dual_timeout", 32'(!pad_b.frame_done), 32'd0);
    end
    check("dual_word",  32'(b_word), 32'hFFF123);
    check("dual_low",   32'(b_word[11:0]), 32'h123);
    check("dual_high",  32'(b_word[23:12]), 32'hFFF);
    check("dual_rises", 32'(b_rises_at_latch), 32'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
